// File: rtl/input_dev_pkg.sv
// Shared definitions for the input_dev register block: register offsets,
// CTRL/STAT bit positions and the event-state encoding.
package input_dev_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] OFS_DATA  = 4'h0;
  localparam logic [3:0] OFS_CTRL  = 4'h4;
  localparam logic [3:0] OFS_STAT  = 4'h8;
  localparam logic [3:0] OFS_COUNT = 4'hC;

  // The bridge hands over byte address bits [3:2] as a word index.
  localparam logic [1:0] ADDR_DATA  = OFS_DATA[3:2];
  localparam logic [1:0] ADDR_CTRL  = OFS_CTRL[3:2];
  localparam logic [1:0] ADDR_STAT  = OFS_STAT[3:2];
  localparam logic [1:0] ADDR_COUNT = OFS_COUNT[3:2];

  localparam int unsigned CTRL_IE   = 0;
  localparam int unsigned CTRL_EN   = 1;
  localparam int unsigned STAT_PEND = 0;
  localparam int unsigned STAT_OVF  = 1;

  // Encoded as {ovf, pend} so the state reads back directly as STAT.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PEND = 2'b01,
    ST_OVF  = 2'b11
  } evt_state_e;

endpackage

// File: rtl/input_dev_chg_detect.sv
// Two-stage input sampling pipeline with change comparator; the pipeline
// runs regardless of the capture enable.
module chg_detect
  import input_dev_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              en,
  output logic              change,
  output logic [DATA_W-1:0] in_q
);

  logic [DATA_W-1:0] in_qd;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '0;
      in_qd <= '0;
    end else begin
      in_q  <= in_data;
      in_qd <= in_q;
    end
  end

  assign change = en & (in_q != in_qd);

endmodule

// File: rtl/input_dev.sv
// Memory-mapped input-port device: captures input changes into DATA/COUNT,
// tracks pending/overflow events and raises a maskable level interrupt.
module input_dev
  import input_dev_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        dev_addr,
  input  logic              dev_we,
  input  logic [DATA_W-1:0] dev_wd,
  output logic [DATA_W-1:0] dev_rd,
  output logic              irq
);

  logic              change;
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] data_r;
  logic              ie;
  logic              en;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] count_rd;
  evt_state_e        state;
  logic [1:0]        stat_bits;
  logic              ctrl_wr;
  logic              ack;
  logic              unused_wd;

  chg_detect u_chg_detect (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .en      (en),
    .change  (change),
    .in_q    (in_q)
  );

  assign ctrl_wr   = dev_we && (dev_addr == ADDR_CTRL);
  assign ack       = dev_we && (dev_addr == ADDR_STAT) && dev_wd[STAT_PEND];
  assign unused_wd = ^dev_wd[DATA_W-1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_r <= '0;
      ie     <= 1'b0;
      en     <= 1'b0;
      count  <= '0;
    end else begin
      if (ctrl_wr) begin
        ie <= dev_wd[CTRL_IE];
        en <= dev_wd[CTRL_EN];
      end
      if (change) begin
        data_r <= in_q;
        count  <= count + CNT_W'(1);
      end
      // A change coinciding with an ack restarts at PEND: the acked event is dropped.
      case (state)
        ST_IDLE: if (change) state <= ST_PEND;
        ST_PEND: begin
          if (change)   state <= ack ? ST_PEND : ST_OVF;
          else if (ack) state <= ST_IDLE;
        end
        ST_OVF: begin
          if (change)   state <= ack ? ST_PEND : ST_OVF;
          else if (ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stat_bits = state;
  assign irq       = stat_bits[STAT_PEND] & ie;

  if (CNT_W >= DATA_W) begin : g_cnt_trunc
    assign count_rd = count[DATA_W-1:0];
  end else begin : g_cnt_ext
    assign count_rd = {{(DATA_W-CNT_W){1'b0}}, count};
  end

  always_comb begin
    dev_rd = '0;
    case (dev_addr)
      ADDR_DATA: dev_rd = data_r;
      ADDR_CTRL: begin
        dev_rd[CTRL_IE] = ie;
        dev_rd[CTRL_EN] = en;
      end
      ADDR_STAT:  dev_rd[1:0] = stat_bits;
      ADDR_COUNT: dev_rd = count_rd;
      default:    dev_rd = '0;
    endcase
  end

endmodule
